// File: rtl/sid_pkg.sv
// Shared widths and types for the SID audio back end (decimator + I2S transmitter).
package sid_pkg;
   localparam int SAMPLE_W       = 16;
   localparam int I2S_WORD_W     = 16;
   localparam int I2S_FRAME_BITS = 32;
   localparam int BIT_CNT_W      = $clog2(I2S_FRAME_BITS);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

   // Word select for a given frame bit: high from one bit before the right MSB to the
   // second-to-last bit, so LRCK leads each word's MSB by one BCLK.
   function automatic logic lrck_for_bit(input logic [BIT_CNT_W-1:0] cnt);
      return (cnt >= BIT_CNT_W'(I2S_WORD_W - 1)) && (cnt != BIT_CNT_W'(I2S_FRAME_BITS - 1));
   endfunction
endpackage

// File: rtl/sid_decim.sv
// Box-car decimator: sums 2^AVG_SHIFT enabled samples, holds the floored mean and
// flags each update with a one-cycle strobe.
module sid_decim
   import sid_pkg::*;
#(
   parameter int AVG_SHIFT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clken,
   input  logic [SAMPLE_W-1:0] i_sample,
   output logic [SAMPLE_W-1:0] o_hold,
   output logic                o_hold_stb
);

   logic [SAMPLE_W-1:0] r_hold;
   logic                r_stb;

   generate
      if (AVG_SHIFT == 0) begin : g_pass
         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_hold <= '0;
               r_stb  <= 1'b0;
            end else begin
               r_stb <= i_clken;
               if (i_clken) r_hold <= i_sample;
            end
         end
      end else begin : g_avg
         localparam int ACC_W = SAMPLE_W + AVG_SHIFT;

         logic [ACC_W-1:0]     r_acc;
         logic [AVG_SHIFT-1:0] r_tick;
         logic [ACC_W-1:0]     w_ext;
         logic [ACC_W-1:0]     w_sum;

         // The accumulator is wide enough for 2^AVG_SHIFT full-scale samples, so
         // two's-complement addition on sign-extended values cannot wrap.
         assign w_ext = {{AVG_SHIFT{i_sample[SAMPLE_W-1]}}, i_sample};
         assign w_sum = r_acc + w_ext;

         always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
               r_acc  <= '0;
               r_tick <= '0;
               r_hold <= '0;
               r_stb  <= 1'b0;
            end else begin
               r_stb <= 1'b0;
               if (i_clken) begin
                  if (r_tick == '1) begin
                     // Taking the top bits is an arithmetic shift that floors toward -inf.
                     r_hold <= w_sum[ACC_W-1:AVG_SHIFT];
                     r_acc  <= '0;
                     r_tick <= '0;
                     r_stb  <= 1'b1;
                  end else begin
                     r_acc  <= w_sum;
                     r_tick <= r_tick + 1'b1;
                  end
               end
            end
         end
      end
   endgenerate

   assign o_hold     = r_hold;
   assign o_hold_stb = r_stb;

endmodule

// File: rtl/sid_i2s_tx.sv
// SID output stage: decimates the mixer stream and transmits the held sample as
// 16-bit mono-duplicated I2S with locally generated BCLK/LRCK.
module sid_i2s_tx
   import sid_pkg::*;
#(
   parameter int BCLK_DIV  = 8,
   parameter int AVG_SHIFT = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_clken,
   input  logic [SAMPLE_W-1:0] i_sample,
   output logic [SAMPLE_W-1:0] o_hold,
   output logic                o_hold_stb,
   output logic                o_i2s_bclk,
   output logic                o_i2s_lrck,
   output logic                o_i2s_sdata
);

   localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

   logic [SAMPLE_W-1:0]       w_hold;
   logic                      w_div_wrap;
   logic                      w_fall;
   logic [BIT_CNT_W-1:0]      w_cnt_next;
   logic [I2S_FRAME_BITS-1:0] w_shreg_next;

   logic [DIV_W-1:0]          r_div;
   logic                      r_bclk;
   logic                      r_lrck;
   logic                      r_sdata;
   logic [BIT_CNT_W-1:0]      r_bit_cnt;
   logic [I2S_FRAME_BITS-1:0] r_shreg;

   sid_decim #(
      .AVG_SHIFT (AVG_SHIFT)
   ) u_decim (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_clken    (i_clken),
      .i_sample   (i_sample),
      .o_hold     (w_hold),
      .o_hold_stb (o_hold_stb)
   );

   assign w_div_wrap = (r_div == DIV_W'(BCLK_DIV - 1));
   assign w_fall     = w_div_wrap & r_bclk;

   // Frame load samples the HOLD register as it stands before this edge, so a
   // coincident decimator update is carried by the following frame.
   always_comb begin
      w_cnt_next = r_bit_cnt + 1'b1;
      if (w_cnt_next == '0) w_shreg_next = {w_hold, w_hold};
      else                  w_shreg_next = {r_shreg[I2S_FRAME_BITS-2:0], 1'b0};
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_div     <= '0;
         r_bclk    <= 1'b0;
         r_lrck    <= 1'b0;
         r_sdata   <= 1'b0;
         r_bit_cnt <= '1;
         r_shreg   <= '0;
      end else begin
         if (w_div_wrap) begin
            r_div  <= '0;
            r_bclk <= ~r_bclk;
         end else begin
            r_div  <= r_div + 1'b1;
         end
         if (w_fall) begin
            r_bit_cnt <= w_cnt_next;
            r_shreg   <= w_shreg_next;
            r_sdata   <= w_shreg_next[I2S_FRAME_BITS-1];
            r_lrck    <= lrck_for_bit(w_cnt_next);
         end
      end
   end

   assign o_hold      = w_hold;
   assign o_i2s_bclk  = r_bclk;
   assign o_i2s_lrck  = r_lrck;
   assign o_i2s_sdata = r_sdata;

endmodule

// File: tb/tb_sid_i2s_tx.sv
// Directed bench for sid_i2s_tx: three instances cover averaging (x16, x2), pass-through,
// I2S framing, reset abort and a HOLD update coincident with a frame load.
module tb_sid_i2s_tx;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        clken;
   logic [15:0] sample;

   wire  [15:0] hold_a, hold_b, hold_c;
   wire  [2:0]  stb, bclk, lrck, sdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] data, lr;
   int          cyc;

   always #5 clk = ~clk;

   sid_i2s_tx #(.BCLK_DIV(2), .AVG_SHIFT(4)) dut_a (
      .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_sample(sample),
      .o_hold(hold_a), .o_hold_stb(stb[0]), .o_i2s_bclk(bclk[0]),
      .o_i2s_lrck(lrck[0]), .o_i2s_sdata(sdata[0])
   );

   sid_i2s_tx #(.BCLK_DIV(8), .AVG_SHIFT(1)) dut_b (
      .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_sample(sample),
      .o_hold(hold_b), .o_hold_stb(stb[1]), .o_i2s_bclk(bclk[1]),
      .o_i2s_lrck(lrck[1]), .o_i2s_sdata(sdata[1])
   );

   sid_i2s_tx #(.BCLK_DIV(2), .AVG_SHIFT(0)) dut_c (
      .i_clk(clk), .i_rst_n(rst_n), .i_clken(clken), .i_sample(sample),
      .o_hold(hold_c), .o_hold_stb(stb[2]), .o_i2s_bclk(bclk[2]),
      .o_i2s_lrck(lrck[2]), .o_i2s_sdata(sdata[2])
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_tick(input logic [15:0] s);
      @(negedge clk);
      clken  = 1'b1;
      sample = s;
      @(negedge clk);
      clken  = 1'b0;
   endtask

   // Returns at the negedge just after the next BCLK falling edge of instance sel.
   task automatic wait_fall(input int sel, output int n);
      logic prev;
      bit   found;
      found = 1'b0;
      n     = 0;
      prev  = bclk[sel];
      while (!found && n < 200) begin
         @(negedge clk);
         n++;
         if (prev && !bclk[sel]) found = 1'b1;
         prev = bclk[sel];
      end
      if (!found) begin
         checks++;
         errors++;
         $error("FAIL bclk_fall_timeout dut %0d waited %0d cycles", sel, n);
      end
   endtask

   // Returns just after the bit-31 fall (LRCK 1->0); the next fall loads bit 0.
   task automatic sync_frame(input int sel);
      logic prev_lr;
      int   n;
      bit   found;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         prev_lr = lrck[sel];
         wait_fall(sel, n);
         if (prev_lr && !lrck[sel]) found = 1'b1;
      end
      if (!found) begin
         checks++;
         errors++;
         $error("FAIL frame_sync_timeout dut %0d", sel);
      end
   endtask

   task automatic capture_frame(input int sel, input bit first_now,
                                output logic [31:0] d, output logic [31:0] l, output int total);
      int n;
      total = 0;
      for (int k = 0; k < 32; k++) begin
         if (!(k == 0 && first_now)) begin
            wait_fall(sel, n);
            total += n;
         end
         d[31-k] = sdata[sel];
         l[31-k] = lrck[sel];
      end
   endtask

   initial begin
      rst_n  = 1'b0;
      clken  = 1'b0;
      sample = 16'h0000;
      repeat (3) @(negedge clk);
      check("rst_hold",  {16'h0, hold_a}, 32'h0);
      check("rst_stb",   {31'h0, stb[0]},   32'h0);
      check("rst_bclk",  {31'h0, bclk[0]},  32'h0);
      check("rst_lrck",  {31'h0, lrck[0]},  32'h0);
      check("rst_sdata", {31'h0, sdata[0]}, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Constant 0x1234 averaged over 16 ticks
      for (int i = 0; i < 15; i++) do_tick(16'h1234);
      check("avg16_stb_early",  {31'h0, stb[0]}, 32'h0);
      check("avg16_hold_early", {16'h0, hold_a}, 32'h0);
      do_tick(16'h1234);
      check("avg16_stb",  {31'h0, stb[0]}, 32'h1);
      check("avg16_hold", {16'h0, hold_a}, 32'h1234);
      @(negedge clk);
      check("avg16_stb_drop", {31'h0, stb[0]}, 32'h0);

      // Framing with BCLK_DIV=2: 4-CLK BCLK, 128-CLK frame, LRCK high 16 BCLK
      sync_frame(0);
      capture_frame(0, 1'b0, data, lr, cyc);
      check("frame_data_1234", data, 32'h1234_1234);
      check("frame_lrck",      lr,   32'h0001_FFFE);
      check("frame_cycles",    cyc,  32'd128);
      wait_fall(0, cyc);
      check("bclk_period", cyc, 32'd4);

      // Full-scale alternation and saturation-free extremes
      for (int i = 0; i < 16; i++) do_tick(i[0] ? 16'h8000 : 16'h7FFF);
      check("alt_hold_x2",  {16'h0, hold_b}, 32'hFFFF);
      check("alt_hold_x16", {16'h0, hold_a}, 32'hFFFF);
      for (int i = 0; i < 16; i++) do_tick(16'h7FFF);
      check("max_hold_x16", {16'h0, hold_a}, 32'h7FFF);
      check("max_hold_x2",  {16'h0, hold_b}, 32'h7FFF);
      for (int i = 0; i < 16; i++) do_tick(16'h8000);
      check("min_hold_x16", {16'h0, hold_a}, 32'h8000);
      for (int i = 0; i < 16; i++) do_tick(i[0] ? 16'h0000 : 16'hFFFF);
      check("floor_neg_x2",  {16'h0, hold_b}, 32'hFFFF);
      check("floor_neg_x16", {16'h0, hold_a}, 32'hFFFF);
      for (int i = 0; i < 16; i++) do_tick(i[0] ? 16'h0000 : 16'h0001);
      check("floor_pos_x2",  {16'h0, hold_b}, 32'h0000);
      check("floor_pos_x16", {16'h0, hold_a}, 32'h0000);

      // Pass-through instance
      do_tick(16'h0001);
      check("pass_hold_0001", {16'h0, hold_c}, 32'h0001);
      check("pass_stb_0001",  {31'h0, stb[2]}, 32'h1);
      @(negedge clk);
      check("pass_stb_drop", {31'h0, stb[2]}, 32'h0);
      do_tick(16'h8000);
      check("pass_hold_8000", {16'h0, hold_c}, 32'h8000);
      do_tick(16'h7FFF);
      check("pass_hold_7fff", {16'h0, hold_c}, 32'h7FFF);
      check("pass_stb_7fff",  {31'h0, stb[2]}, 32'h1);
      do_tick(16'hA5C3);
      check("pass_hold_a5c3", {16'h0, hold_c}, 32'hA5C3);

      // HOLD update on the same edge as the bit-0 load (4 CLK after the bit-31 fall)
      sync_frame(2);
      repeat (3) @(negedge clk);
      clken  = 1'b1;
      sample = 16'h3C5A;
      @(negedge clk);
      clken  = 1'b0;
      check("coinc_hold", {16'h0, hold_c}, 32'h3C5A);
      capture_frame(2, 1'b1, data, lr, cyc);
      check("coinc_frame_old", data, 32'hA5C3_A5C3);
      capture_frame(2, 1'b0, data, lr, cyc);
      check("coinc_frame_new", data, 32'h3C5A_3C5A);

      // dut_a holds 5 ticks (1,8000,7FFF,A5C3,3C5A); 11 more of 0x5555 -> 232644>>>4
      for (int i = 0; i < 11; i++) do_tick(16'h5555);
      check("mixed_hold_x16", {16'h0, hold_a}, 32'h38CC);

      // Reset in the right word, while BCLK is high
      sync_frame(0);
      repeat (82) @(negedge clk);
      check("pre_rst_lrck", {31'h0, lrck[0]}, 32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_hold",  {16'h0, hold_a},  32'h0);
      check("midrst_bclk",  {31'h0, bclk[0]}, 32'h0);
      check("midrst_lrck",  {31'h0, lrck[0]}, 32'h0);
      check("midrst_sdata", {31'h0, sdata[0]}, 32'h0);
      check("midrst_stb",   {31'h0, stb[0]},  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      capture_frame(0, 1'b0, data, lr, cyc);
      check("post_rst_data",   data, 32'h0);
      check("post_rst_lrck",   lr,   32'h0001_FFFE);
      check("post_rst_cycles", cyc,  32'd128);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
